fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch control stage that sits directly upstream of the 8-bit program-counter register.
- Drives the PC's latch/inc/data inputs and consumes its output value as the fetch address.
- Reads 1- or 2-byte instructions from program memory over a req/ack handshake.
- Presents each assembled instruction to the decoder through a valid/ready handshake.

Parameters:
- DATA_W, 8, width of memory data, opcode and operand.
- ADDR_W, 8, width of PC value and memory address.
- LONG_BIT, 7, opcode bit that marks a 2-byte instruction (opcode + operand).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- run  input  1  1 = fetch continuously; 0 = stop at the next instruction boundary.
- pc_value  input  ADDR_W  current PC register output.
- pc_inc  output  1  PC increment strobe, sampled by the PC on the next clk edge.
- pc_latch  output  1  PC load strobe.
- pc_data  output  ADDR_W  PC load value.
- mem_req  output  1  program-memory read request.
- mem_addr  output  ADDR_W  read address; always equals pc_value.
- mem_ack  input  1  read complete; mem_rdata valid this cycle; ignored when mem_req=0.
- mem_rdata  input  DATA_W  read data.
- redirect  input  1  jump request from execute (single-cycle pulse).
- redirect_addr  input  ADDR_W  jump target.
- instr_valid  output  1  opcode/operand valid to decoder.
- instr_ready  input  1  decoder accepts.
- opcode  output  DATA_W  fetched opcode.
- operand  output  DATA_W  fetched operand; 0 for 1-byte instructions.
- halted  output  1  1 when in S_IDLE.
- instr_count  output  8  count of instructions issued; wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = S_IDLE.
  - opcode, operand, instr_count = 0.
  - instr_valid, mem_req, pc_inc, pc_latch = 0; pc_data = 0.
  - Reset mid-fetch abandons the fetch with no PC strobe.
- States: S_IDLE, S_OP_REQ, S_IMM_REQ, S_ISSUE.
- S_IDLE:
  - halted=1, no requests.
  - run=1 -> S_OP_REQ next cycle.
- S_OP_REQ:
  - mem_req=1, mem_addr=pc_value; hold until mem_ack.
  - On ack: opcode<=mem_rdata and pc_inc=1 in the same cycle (combinational: mem_req & mem_ack & ~redirect).
  - If mem_rdata[LONG_BIT]=1 -> S_IMM_REQ; else operand<=0 -> S_ISSUE.
- S_IMM_REQ:
  - Same as S_OP_REQ; on ack operand<=mem_rdata, pc_inc=1 -> S_ISSUE.
  - mem_addr already reflects the incremented PC because the FSM spends at least one cycle in the new state.
- S_ISSUE:
  - instr_valid=1; opcode/operand held stable while instr_valid=1 and instr_ready=0.
  - Handshake (valid & ready): instr_count+1.
  - Next state: run=1 -> S_OP_REQ, else S_IDLE.
  - No bubble between handshake and the next request.
- Latency with zero-wait memory (ack in the request cycle):
  - 1-byte instruction: valid 1 cycle after the request starts.
  - 2-byte instruction: valid 2 cycles after the request starts.
- redirect=1 (any state except S_IDLE):
  - pc_latch=1 and pc_data=redirect_addr combinationally in the same cycle; pc_inc forced 0.
  - Any concurrent mem_ack data is discarded; instr_valid drops next cycle without handshake (flush).
  - Next state S_OP_REQ; instr_count unchanged.
- redirect in S_IDLE:
  - PC is loaded (pc_latch=1), state stays S_IDLE.
- Simultaneous redirect with an S_ISSUE handshake:
  - The handshake completes (count+1); the redirect still loads the PC and the next fetch is from the target.
- run=0 mid-instruction:
  - The current instruction completes and issues, then the FSM goes to S_IDLE.
- pc_inc and pc_latch are never both 1.
- PC wrap (0xFF -> 0x00) is the PC register's job; no special handling here.

Decomposition:
- fetch_pkg:
  - state enum (S_IDLE, S_OP_REQ, S_IMM_REQ, S_ISSUE).
  - LONG_BIT default.
  - Localparams for the reset values.
- No sub-module. The PC register stays a sibling instance at the CPU top level, wired pc_inc->inc, pc_latch->latch, pc_data->data, reg_out->pc_value.

Test Plan:
- Reset held low 2 cycles, run=1, then release -> all outputs 0, halted=1 during reset; mem_req=1 at addr 0x00 on the first cycle after S_IDLE.
- Memory 0x00=0x12, zero-wait, ready=1 -> pc_inc pulses once, opcode=0x12, operand=0x00, instr_valid=1 for one cycle, instr_count=1, next mem_addr=0x01.
- Memory 0x01=0x85, 0x02=0x3C, ack delayed 2 cycles each -> two pc_inc pulses, opcode=0x85, operand=0x3C, PC=0x03 at issue.
- instr_ready held 0 for 5 cycles in S_ISSUE -> instr_valid stays 1, opcode/operand stable, no mem_req, count unchanged until ready.
- redirect=1 with target 0x40 in the same cycle as the mem_ack of opcode 0x90 -> pc_latch=1, pc_data=0x40, pc_inc=0, data dropped, next mem_addr=0x40, no instr_valid for 0x90.
- run=0 during S_IMM_REQ -> instruction still issues, then halted=1 and mem_req stays 0.
- Separately: issue 256 instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

  localparam int FETCH_DATA_W   = 8;
  localparam int FETCH_ADDR_W   = 8;
  localparam int FETCH_LONG_BIT = 7;
  localparam int COUNT_W        = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP_REQ,
    S_IMM_REQ,
    S_ISSUE
  } state_e;

  localparam logic [FETCH_DATA_W-1:0] RST_OPCODE  = '0;
  localparam logic [FETCH_DATA_W-1:0] RST_OPERAND = '0;
  localparam logic [COUNT_W-1:0]      RST_COUNT   = '0;

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetches 1/2-byte instructions, steps the PC and hands them to the decoder
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int DATA_W   = FETCH_DATA_W,
  parameter int ADDR_W   = FETCH_ADDR_W,
  parameter int LONG_BIT = FETCH_LONG_BIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic               pc_inc,
  output logic               pc_latch,
  output logic [ADDR_W-1:0]  pc_data,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [DATA_W-1:0]  opcode,
  output logic [DATA_W-1:0]  operand,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  state_e              r_state;
  logic                r_mem_req;
  logic                r_instr_valid;
  logic [DATA_W-1:0]   r_opcode;
  logic [DATA_W-1:0]   r_operand;
  logic [COUNT_W-1:0]  r_instr_count;

  logic                w_handshake;

  assign w_handshake = r_instr_valid & instr_ready;

  // The PC strobes are combinational so the PC steps on the same edge that captures the byte.
  assign pc_inc      = r_mem_req & mem_ack & ~redirect;
  assign pc_latch    = redirect & reset;
  assign pc_data     = pc_latch ? redirect_addr : '0;

  assign mem_req     = r_mem_req;
  assign mem_addr    = pc_value;
  assign instr_valid = r_instr_valid;
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign instr_count = r_instr_count;
  assign halted      = (r_state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_opcode      <= DATA_W'(RST_OPCODE);
      r_operand     <= DATA_W'(RST_OPERAND);
      r_instr_count <= RST_COUNT;
    end else begin
      if (w_handshake) begin
        r_instr_count <= r_instr_count + COUNT_W'(1);
      end

      // A redirect discards any in-flight byte or unaccepted instruction and refetches.
      if (redirect) begin
        if (r_state != S_IDLE) begin
          r_state       <= S_OP_REQ;
          r_mem_req     <= 1'b1;
          r_instr_valid <= 1'b0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (run) begin
              r_state   <= S_OP_REQ;
              r_mem_req <= 1'b1;
            end
          end
          S_OP_REQ: begin
            if (mem_ack) begin
              r_opcode <= mem_rdata;
              if (mem_rdata[LONG_BIT]) begin
                r_state <= S_IMM_REQ;
              end else begin
                r_operand     <= '0;
                r_state       <= S_ISSUE;
                r_mem_req     <= 1'b0;
                r_instr_valid <= 1'b1;
              end
            end
          end
          S_IMM_REQ: begin
            if (mem_ack) begin
              r_operand     <= mem_rdata;
              r_state       <= S_ISSUE;
              r_mem_req     <= 1'b0;
              r_instr_valid <= 1'b1;
            end
          end
          S_ISSUE: begin
            if (instr_ready) begin
              r_instr_valid <= 1'b0;
              if (run) begin
                r_state   <= S_OP_REQ;
                r_mem_req <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with a PC register and memory model
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [7:0] pc_value;
  logic       pc_inc;
  logic       pc_latch;
  logic [7:0] pc_data;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       redirect;
  logic [7:0] redirect_addr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic       halted;
  logic [7:0] instr_count;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .pc_value      (pc_value),
    .pc_inc        (pc_inc),
    .pc_latch      (pc_latch),
    .pc_data       (pc_data),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sibling PC register
  logic [7:0] pc;
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= 8'h00;
    else if (pc_latch) pc <= pc_data;
    else if (pc_inc) pc <= pc + 8'd1;
  end
  assign pc_value = pc;

  // Program memory with configurable wait states (wait_cfg < 0 picks random 0..3)
  logic [7:0] mem [256];
  int  wait_cfg;
  int  wl;
  bit  pending = 1'b0;
  bit  acked = 1'b0;
  always @(posedge clk) begin
    #2;
    if (acked) pending = 1'b0;
    acked = 1'b0;
    if (!reset) begin
      pending = 1'b0;
      mem_ack = 1'b0;
    end else if (mem_req) begin
      if (!pending) begin
        pending = 1'b1;
        wl = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
      end else if (wl > 0) begin
        wl--;
      end
      if (wl == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        acked     = 1'b1;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end else begin
      pending   = 1'b0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
    end
  end

  // Instruction-stream reference: program order from the PC, a redirect restarts at its target
  typedef struct {
    logic [7:0] op;
    logic [7:0] opd;
    int         len;
  } exp_t;
  exp_t       q[$];
  exp_t       e;
  logic [7:0] mpc = 8'h00;
  logic [7:0] m_count = 8'h00;
  int         hs_since_reset = 0;
  int         inc_since = 0;
  bit         prev_stall = 1'b0;
  bit         prev_redirect = 1'b0;
  logic [7:0] prev_op, prev_opd;

  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_quiet", {pc_inc, pc_latch, mem_req, instr_valid, halted}, 64'b00001);
      q.delete();
      mpc = 8'h00;
      m_count = 8'h00;
      hs_since_reset = 0;
      inc_since = 0;
      prev_stall = 1'b0;
      prev_redirect = 1'b0;
    end else begin
      chk("addr_is_pc", mem_addr, pc);
      if (pc_inc && pc_latch) chk("strobe_exclusive", {pc_inc, pc_latch}, 64'b00);
      chk("latch_follows_redirect", pc_latch, redirect);
      if (pc_latch) chk("pc_data", pc_data, redirect_addr);
      if (instr_valid) chk("no_req_in_issue", mem_req, 1'b0);
      if (prev_redirect) chk("flush_valid", instr_valid, 1'b0);
      if (instr_valid && prev_stall) chk("stall_stable", {opcode, operand}, {prev_op, prev_opd});
      if (pc_inc) inc_since++;
      if (instr_valid && instr_ready) begin
        if (q.size() == 0) begin
          e.op = mem[mpc];
          if (e.op[7]) begin
            e.opd = mem[mpc + 8'd1];
            e.len = 2;
            mpc = mpc + 8'd2;
          end else begin
            e.opd = 8'h00;
            e.len = 1;
            mpc = mpc + 8'd1;
          end
          q.push_back(e);
        end
        e = q.pop_front();
        chk("issue_instr", {opcode, operand}, {e.op, e.opd});
        chk("inc_per_instr", inc_since, e.len);
        chk("count_before_hs", instr_count, m_count);
        m_count = m_count + 8'd1;
        hs_since_reset++;
        inc_since = 0;
      end
      if (redirect) begin
        q.delete();
        mpc = redirect_addr;
        inc_since = 0;
      end
      prev_stall    = instr_valid && !instr_ready;
      prev_redirect = redirect;
      prev_op       = opcode;
      prev_opd      = operand;
    end
  end

  initial begin
    reset = 1'b0; run = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_addr = 8'h00;
    wait_cfg = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h85; mem[8'h02] = 8'h3C;
    mem[8'h03] = 8'h21; mem[8'h04] = 8'h90;
    mem[8'h40] = 8'h33; mem[8'h41] = 8'hA5; mem[8'h42] = 8'h77;

    repeat (2) begin
      @(negedge clk);
      chk("reset_outputs",
          {halted, mem_req, instr_valid, pc_inc, pc_latch, pc_data, opcode, operand, instr_count},
          {1'b1, 36'b0});
    end
    reset = 1'b1;

    @(negedge clk);
    chk("first_req", {mem_req, mem_addr, pc_inc}, {1'b1, 8'h00, 1'b1});
    @(negedge clk);
    chk("short_latency", {instr_valid, opcode, operand}, {1'b1, 8'h12, 8'h00});
    wait_cfg = 2;
    @(negedge clk);
    chk("after_first", {instr_count, mem_req, mem_addr}, {8'd1, 1'b1, 8'h01});

    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    chk("long_issue", {instr_valid, opcode, operand, pc_value}, {1'b1, 8'h85, 8'h3C, 8'h03});

    @(posedge clk); #1;
    instr_ready = 1'b0;
    wait_cfg = 0;
    for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {instr_valid, mem_req, opcode, operand, instr_count},
          {1'b1, 1'b0, 8'h21, 8'h00, 8'd2});
    end

    @(posedge clk); #1;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_addr = 8'h40;
    @(negedge clk);
    chk("redirect_strobes", {pc_latch, pc_data, pc_inc, mem_ack, mem_rdata},
        {1'b1, 8'h40, 1'b0, 1'b1, 8'h90});
    @(posedge clk); #1;
    redirect = 1'b0;
    wait_cfg = 1;
    @(negedge clk);
    chk("redirect_target", {mem_req, mem_addr, instr_valid, instr_count}, {1'b1, 8'h40, 1'b0, 8'd3});

    for (int i = 0; i < 30 && !(mem_req && mem_addr == 8'h42); i++) @(negedge clk);
    chk("reach_imm_req", {mem_req, mem_addr}, {1'b1, 8'h42});
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
    chk("halt_after_run_low", {halted, instr_count}, {1'b1, 8'd5});
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_req", {mem_req, instr_valid, halted}, {1'b0, 1'b0, 1'b1});
    end

    wait_cfg = -1;
    repeat (1500) begin
      @(posedge clk); #1;
      run           = ($urandom_range(0, 15) != 0);
      instr_ready   = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 11) == 0);
      redirect_addr = 8'($urandom);
    end

    @(posedge clk); #1;
    redirect = 1'b0;
    run = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    instr_ready = 1'b1;
    wait_cfg = 0;
    for (int i = 0; i < 1200 && hs_since_reset < 256; i++) begin
      @(negedge clk); #1;
    end
    chk("issued_256", hs_since_reset, 256);
    @(negedge clk);
    chk("count_wrap", instr_count, 8'h00);

    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
    chk("final_halt", halted, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("final_idle", mem_req, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
